// File: rtl/rca_word_sequencer.sv
// Sequential adder: one SLICE-bit ripple-carry slice per clock, LSB slice first.
// Define RCA_SEQ_OVF_EN to add the signed-overflow output ovf.
module rca_word_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [SLICE:0]   slice_sum;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_carry_in;
`endif

  // The single shared slice adder always works on the low slice of the shift registers.
  assign slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d        = ovf_q;
    msb_carry_in = slice_sum[SLICE-1] ^ a_q[SLICE-1] ^ b_q[SLICE-1];
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        carry_d = slice_sum[SLICE];
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = slice_sum[SLICE];
          state_d = DONE;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = msb_carry_in ^ slice_sum[SLICE];
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // in_ready is gated by rst_n so it stays low for the whole reset cycle.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Randomized and directed checks of rca_word_sequencer against an arithmetic reference model.
module tb_rca_word_sequencer;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rca_word_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation end to end; bp = cycles out_ready is held low in DONE while a
  // new request (na, nb, ncin) is presented on the input side.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic ocin, input int bp,
                        input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                        input logic ncin);
    logic [WIDTH:0] total;
    logic           exp_ovf;
    int             waited;
    int             lat;
    total   = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, ocin};
    exp_ovf = (oa[WIDTH-1] == ob[WIDTH-1]) && (total[WIDTH-1] != oa[WIDTH-1]);
    a = oa; b = ob; cin = ocin; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 32'(waited), 32'd0);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check_eq("in_ready_run", 32'(in_ready), 32'd0);
    check_eq("busy_run", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(NSLICE));
    check_eq("sum", 32'(sum), 32'(total[WIDTH-1:0]));
    check_eq("cout", 32'(cout), 32'(total[WIDTH]));
`ifdef RCA_SEQ_OVF_EN
    check_eq("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    if (bp > 0) begin
      a = na; b = nb; cin = ncin; in_valid = 1'b1;
    end
    for (int i = 0; i < bp; i++) begin
      step();
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_sum", 32'(sum), 32'(total[WIDTH-1:0]));
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("post_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
`ifdef RCA_SEQ_OVF_EN
    check_eq("post_ovf", 32'(ovf), 32'd0);
`endif
    $display("op a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d (exp %05h) lat=%0d bp=%0d",
             oa, ob, ocin, sum, cout, total, lat, bp);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, qa, qb;
    logic             rc, qc;
    int               bp;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    step();
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("release_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h0000, 16'h0000, 1'b0, 0, '0, '0, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0, '0, '0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, '0, '0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, '0, '0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 3, 16'h0F0F, 16'h00F1, 1'b1);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 0, '0, '0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, '0, '0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, '0, '0, 1'b0);

    // Reset abort during the second RUN cycle.
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_sum", 32'(sum), 32'd0);
    check_eq("abort_cout", 32'(cout), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < NSLICE + 2; i++) begin
      step();
      check_eq("abort_no_result", 32'(out_valid), 32'd0);
    end
    $display("reset abort of a=abcd b=1111 checked");

    qa = 16'($urandom); qb = 16'($urandom); qc = 1'($urandom);
    for (int k = 0; k < 40; k++) begin
      ra = qa; rb = qb; rc = qc;
      qa = 16'($urandom); qb = 16'($urandom); qc = 1'($urandom);
      bp = int'($urandom_range(0, 2));
      run_op(ra, rb, rc, bp, qa, qb, qc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
